// File: rtl/sal_fifo_vr_if.sv
// sal_fifo_vr_if: valid/ready write and read channels plus occupancy status of sal_fifo_vr
interface sal_fifo_vr_if #(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DEPTH_LG2:0]    count;
  logic                  full;
  logic                  empty;
  logic                  afull;
  logic                  aempty;
  logic [DEPTH_LG2:0]    max_count;
  modport master (
    output flush, wvalid, wdata, rready,
    input  wready, rvalid, rdata, count, full, empty, afull, aempty, max_count
  );
  modport slave (
    input  flush, wvalid, wdata, rready,
    output wready, rvalid, rdata, count, full, empty, afull, aempty, max_count
  );
endinterface

// File: rtl/sal_fifo_vr.sv
// sal_fifo_vr: FWFT valid/ready FIFO with registered flags, flush and peak-occupancy watermark
module sal_fifo_vr #(
  parameter int DEPTH_LG2    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_THRES  = (1 << DEPTH_LG2) - 1,
  parameter int AEMPTY_THRES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sal_fifo_vr_if.slave   f
);
  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int CW = DEPTH_LG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF = CW'(AFULL_THRES);
  localparam logic [CW-1:0] AE = CW'(AEMPTY_THRES);
  localparam logic [CW-1:0] ONE = CW'(1);
  if (DEPTH_LG2 < 1 || AFULL_THRES < 1 || AFULL_THRES > DEPTH ||
      AEMPTY_THRES < 0 || AEMPTY_THRES > DEPTH - 1) begin : g_bad_thres
    $error("sal_fifo_vr: illegal DEPTH_LG2/AFULL_THRES/AEMPTY_THRES");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] wptr, rptr, cnt_nxt;
  logic push, pop, clr;
  always_comb begin
    clr = ~rst_n | f.flush;
    push = f.wvalid & ~f.full;
    pop = f.rready & ~f.empty;
    cnt_nxt = (push & ~pop) ? f.count + ONE : (pop & ~push) ? f.count - ONE : f.count;
  end
  assign f.wready = ~f.full;
  assign f.rvalid = ~f.empty;
  assign f.rdata = f.empty ? '0 : mem[rptr[DEPTH_LG2-1:0]];
  // storage is never cleared; only writes that are actually accepted land in it
  always_ff @(posedge clk)
    if (push && !clr) mem[wptr[DEPTH_LG2-1:0]] <= f.wdata;
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr        <= '0;
      rptr        <= '0;
      f.count     <= '0;
      f.max_count <= '0;
      f.full      <= 1'b0;
      f.empty     <= 1'b1;
      f.afull     <= 1'b0;
      f.aempty    <= 1'b1;
    end else begin
      wptr        <= push ? wptr + ONE : wptr;
      rptr        <= pop ? rptr + ONE : rptr;
      f.count     <= cnt_nxt;
      f.max_count <= (cnt_nxt > f.max_count) ? cnt_nxt : f.max_count;
      f.full      <= cnt_nxt == FULL_CNT;
      f.empty     <= cnt_nxt == '0;
      f.afull     <= cnt_nxt >= AF;
      f.aempty    <= cnt_nxt <= AE;
    end
  end
endmodule

// File: tb/tb_sal_fifo_vr.sv
// tb_sal_fifo_vr: directed and random traffic against a queue-based reference model of the FIFO
module tb_sal_fifo_vr;
  localparam int LG = 4;
  localparam int DW = 32;
  localparam int DEPTH = 1 << LG;
  logic clk = 1'b0;
  logic rst_n;
  int cmp_cnt = 0;
  int err_cnt = 0;
  bit armed = 1'b0;
  logic [DW-1:0] m_q [$];
  int m_max = 0;
  always #5 clk = ~clk;
  sal_fifo_vr_if #(.DEPTH_LG2(LG), .DATA_WIDTH(DW)) bus ();
  sal_fifo_vr #(.DEPTH_LG2(LG), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .f(bus));
  task automatic check(input string n, input longint unsigned act, input longint unsigned exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
    bus.wvalid = wv;
    bus.wdata = wd;
    bus.rready = rr;
    bus.flush = fl;
    @(posedge clk);
    #1;
  endtask
  // monitor: compare DUT state to the model, then apply the handshake the coming edge will perform
  always @(negedge clk) begin
    int n;
    bit p, q;
    n = m_q.size();
    if (armed) begin
      check("count", bus.count, n);
      check("full", bus.full, n == DEPTH);
      check("empty", bus.empty, n == 0);
      check("afull", bus.afull, n >= DEPTH - 1);
      check("aempty", bus.aempty, n <= 1);
      check("wready", bus.wready, n < DEPTH);
      check("rvalid", bus.rvalid, n > 0);
      check("max_count", bus.max_count, m_max);
      check("rdata", bus.rdata, n > 0 ? m_q[0] : '0);
    end
    if (!rst_n || bus.flush) begin
      m_q.delete();
      m_max = 0;
      armed = 1'b1;
    end else if (armed) begin
      p = bus.wvalid && n < DEPTH;
      q = bus.rready && n > 0;
      if (q) void'(m_q.pop_front());
      if (p) m_q.push_back(bus.wdata);
      if (m_q.size() > m_max) m_max = m_q.size();
    end
  end
  initial begin
    rst_n = 1'b0;
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    rst_n = 1'b1;
    check("reset_count", bus.count, 0);
    check("reset_rdata", bus.rdata, 0);
    for (int i = 1; i <= DEPTH + 1; i++) step(1, DW'(i), 0, 0);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      check("fill_order", bus.rdata, i);
      step(0, '0, 1, 0);
    end
    check("drain_empty", bus.empty, 1);
    step(0, '0, 0, 1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; ) begin
        bit wv;
        wv = $urandom_range(0, 1) == 1;
        step(wv, $urandom, 0, 0);
        if (wv) k++;
      end
      for (int k = 0; k < 10; ) begin
        bit rr;
        rr = $urandom_range(0, 1) == 1;
        step(0, '0, rr, 0);
        if (rr) k++;
      end
    end
    check("wrap_count", bus.count, 0);
    check("wrap_max", bus.max_count, 10);
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
    for (int i = 0; i < 20; i++) step(1, $urandom, 1, 0);
    check("simul_count", bus.count, 5);
    while (bus.count < 5'(DEPTH)) step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    check("full_pushpop", bus.count, DEPTH - 1);
    step(0, '0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 1);
    check("flush_count", bus.count, 0);
    check("flush_max", bus.max_count, 0);
    step(1, 32'hA5, 0, 0);
    check("flush_a5", bus.rdata, 32'hA5);
    step(0, '0, 1, 0);
    for (int i = 0; i < 10000; i++) begin
      rst_n = $urandom_range(0, 999) != 0;
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 499) == 0);
    end
    rst_n = 1'b1;
    step(0, '0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
